// File: rtl/seq_det_pkg.sv
// Shared constants, configuration record and length-mask helper for the
// programmable serial sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  // Config record is sized for the largest supported pattern (32 bits)
  localparam int PAT_W     = 32;
  localparam int CFG_LEN_W = 6;

  typedef struct packed {
    logic [PAT_W-1:0]     pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 ovl;
  } cfg_t;

  function automatic logic [PAT_W-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
    if (len >= CFG_LEN_W'(PAT_W)) begin
      return '1;
    end
    return (PAT_W'(1) << len) - PAT_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_param_sat_cnt.sv
// Generic saturating up-counter with synchronous clear (clear wins over
// increment) and asynchronous active-high reset.
module sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Run-time programmable serial pattern detector: shift history, length-masked
// compare, overlap/non-overlap restart, registered match pulse and count.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               B,
  input  logic               B_Vld,
  input  logic               Cfg_Load,
  input  logic [MAX_LEN-1:0] Pattern,
  input  logic [LEN_W-1:0]   Len,
  input  logic               Ovl,
  input  logic               Cnt_Clr,
  output logic               W,
  output logic [CNT_W-1:0]   Match_Cnt,
  output logic               Cfg_Err
);

  cfg_t               cfg_p0;
  logic               cfg_err_p0;
  logic [MAX_LEN-1:0] hist_p0;
  logic [LEN_W-1:0]   fill_p0;

  logic [MAX_LEN-1:0] hist_nx;
  logic [LEN_W-1:0]   fill_nx;
  logic [PAT_W-1:0]   mask;
  logic               active;
  logic               match;
  logic               len_bad;

  assign len_bad = (Len == '0) || (Len > LEN_W'(MAX_LEN));

  // Fill is the detector's state: 0 = empty, below len = filling, else armed.
  always_comb begin
    hist_nx = (hist_p0 << 1) | MAX_LEN'(B);
    fill_nx = (fill_p0 >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_p0 + LEN_W'(1);
    mask    = len_mask(cfg_p0.len);
    active  = !cfg_err_p0 && (cfg_p0.len != '0);
    match   = B_Vld && !Cfg_Load && active &&
              (CFG_LEN_W'(fill_nx) >= cfg_p0.len) &&
              ((PAT_W'(hist_nx) & mask) == cfg_p0.pattern);
  end

  // ---- stage p0: config, history, fill and match pulse registers ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cfg_p0     <= '{pattern: '0, len: '0, ovl: 1'b1};
      cfg_err_p0 <= 1'b0;
      hist_p0    <= '0;
      fill_p0    <= '0;
      W          <= 1'b0;
    end else begin
      W <= match;
      if (Cfg_Load) begin
        // Stored pattern is pre-masked so the compare needs no second mask
        cfg_p0.pattern <= PAT_W'(Pattern) & len_mask(CFG_LEN_W'(Len));
        cfg_p0.len     <= CFG_LEN_W'(Len);
        cfg_p0.ovl     <= Ovl;
        cfg_err_p0     <= len_bad;
        hist_p0        <= '0;
        fill_p0        <= '0;
      end else if (B_Vld) begin
        hist_p0 <= hist_nx;
        fill_p0 <= (match && !cfg_p0.ovl) ? '0 : fill_nx;
      end
    end
  end

  assign Cfg_Err = cfg_err_p0;

  sat_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (Clk),
    .rst (Rst),
    .clr (Cnt_Clr),
    .inc (match),
    .cnt (Match_Cnt)
  );

endmodule

// File: tb/tb_seq_det_param.sv
// Directed and randomized bench for seq_det_param against a queue-based
// model of "bits received since the detector last restarted".
module tb_seq_det_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               B;
  logic               B_Vld;
  logic               Cfg_Load;
  logic [MAX_LEN-1:0] Pattern;
  logic [LEN_W-1:0]   Len;
  logic               Ovl;
  logic               Cnt_Clr;
  logic               W;
  logic [CNT_W-1:0]   Match_Cnt;
  logic               Cfg_Err;

  seq_det_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .B         (B),
    .B_Vld     (B_Vld),
    .Cfg_Load  (Cfg_Load),
    .Pattern   (Pattern),
    .Len       (Len),
    .Ovl       (Ovl),
    .Cnt_Clr   (Cnt_Clr),
    .W         (W),
    .Match_Cnt (Match_Cnt),
    .Cfg_Err   (Cfg_Err)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit         q[$];
  int         m_len;
  logic [7:0] m_pat;
  bit         m_ovl;
  bit         m_err;
  bit         m_w;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_len = 0;
    m_pat = '0;
    m_ovl = 1'b1;
    m_err = 1'b0;
    m_w   = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit b, input bit vld, input bit ld, input bit clr,
                            input logic [7:0] p, input int l, input bit o);
    bit hit;
    m_w = 1'b0;
    if (ld) begin
      m_pat = p;
      m_len = l;
      m_ovl = o;
      m_err = (l == 0) || (l > MAX_LEN);
      q.delete();
    end else if (vld) begin
      q.push_back(b);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (!m_err && m_len > 0 && q.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        if (hit) begin
          m_w = 1'b1;
          if (!m_ovl) q.delete();
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (m_w && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic step(input string tag, input bit b, input bit vld, input bit ld,
                      input bit clr, input logic [7:0] p, input int l, input bit o);
    B        = b;
    B_Vld    = vld;
    Cfg_Load = ld;
    Cnt_Clr  = clr;
    Pattern  = p;
    Len      = LEN_W'(l);
    Ovl      = o;
    model_step(b, vld, ld, clr, p, l, o);
    @(posedge Clk);
    #1;
    chk({tag, "_w"},   32'(W),         32'(m_w));
    chk({tag, "_cnt"}, 32'(Match_Cnt), 32'(m_cnt));
    chk({tag, "_err"}, 32'(Cfg_Err),   32'(m_err));
  endtask

  task automatic bit_in(input string tag, input bit b);
    step(tag, b, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic idle(input string tag, input bit clr);
    step(tag, 1'($urandom), 1'b0, 1'b0, clr, 8'h00, 0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [7:0] p, input int l, input bit o);
    step(tag, 1'b1, 1'b1, 1'b1, 1'b0, p, l, o);
  endtask

  initial begin
    bit s7[7];
    s7 = '{1, 1, 0, 1, 1, 0, 1};
    Rst = 1'b1; B = 0; B_Vld = 0; Cfg_Load = 0; Pattern = '0; Len = '0; Ovl = 0; Cnt_Clr = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_w", 32'(W), 32'd0);
    chk("rst_cnt", 32'(Match_Cnt), 32'd0);
    chk("rst_err", 32'(Cfg_Err), 32'd0);
    Rst = 1'b0;

    // Idle after reset: Len=0, nothing may match
    for (int i = 0; i < 6; i++) bit_in("idle_len0", 1'b1);

    // Test 1: 1101 overlapping
    load("t1_load", 8'b1101, 4, 1'b1);
    for (int i = 0; i < 7; i++) bit_in("t1", s7[i]);
    chk("t1_total", 32'(Match_Cnt), 32'd2);

    // Test 2: 1101 non-overlapping
    idle("t2_clr", 1'b1);
    load("t2_load", 8'b1101, 4, 1'b0);
    for (int i = 0; i < 7; i++) bit_in("t2", s7[i]);
    chk("t2_total", 32'(Match_Cnt), 32'd1);

    // Test 3: 11 overlap, then non-overlap
    idle("t3_clr", 1'b1);
    load("t3a_load", 8'b11, 2, 1'b1);
    for (int i = 0; i < 4; i++) bit_in("t3a", 1'b1);
    chk("t3a_total", 32'(Match_Cnt), 32'd3);
    idle("t3b_clr", 1'b1);
    load("t3b_load", 8'b11, 2, 1'b0);
    for (int i = 0; i < 4; i++) bit_in("t3b", 1'b1);
    chk("t3b_total", 32'(Match_Cnt), 32'd2);

    // Test 4: gapped valid bits
    idle("t4_clr", 1'b1);
    load("t4_load", 8'b1101, 4, 1'b1);
    bit_in("t4_b0", 1'b1);
    for (int g = 0; g < 3; g++) idle("t4_gap0", 1'b0);
    bit_in("t4_b1", 1'b1);
    for (int g = 0; g < 3; g++) idle("t4_gap1", 1'b0);
    bit_in("t4_b2", 1'b0);
    for (int g = 0; g < 3; g++) idle("t4_gap2", 1'b0);
    bit_in("t4_b3", 1'b1);
    chk("t4_pulse", 32'(W), 32'd1);
    idle("t4_after", 1'b0);
    chk("t4_total", 32'(Match_Cnt), 32'd1);

    // Test 5: illegal lengths, recovery, mid-pattern reset
    load("t5_len0", 8'hFF, 0, 1'b1);
    for (int i = 0; i < 6; i++) bit_in("t5_len0_s", 1'($urandom));
    chk("t5_err0", 32'(Cfg_Err), 32'd1);
    load("t5_len9", 8'hFF, MAX_LEN + 1, 1'b1);
    for (int i = 0; i < 12; i++) bit_in("t5_len9_s", 1'b1);
    chk("t5_err9", 32'(Cfg_Err), 32'd1);
    load("t5_ok", 8'b1101, 4, 1'b1);
    chk("t5_errclr", 32'(Cfg_Err), 32'd0);
    bit_in("t5_p", 1'b1);
    bit_in("t5_p", 1'b1);
    bit_in("t5_p", 1'b0);
    bit_in("t5_p", 1'b1);
    chk("t5_w_before_rst", 32'(W), 32'd1);
    Rst = 1'b1;
    #2;
    chk("t5_rst_w", 32'(W), 32'd0);
    chk("t5_rst_cnt", 32'(Match_Cnt), 32'd0);
    chk("t5_rst_err", 32'(Cfg_Err), 32'd0);
    #2;
    Rst = 1'b0;
    model_reset();
    load("t5_reload", 8'b1101, 4, 1'b1);
    bit_in("t5_lost", 1'b1);
    chk("t5_partial_gone", 32'(W), 32'd0);
    bit_in("t5_q", 1'b1);
    bit_in("t5_q", 1'b0);
    bit_in("t5_q", 1'b1);
    chk("t5_fresh_match", 32'(W), 32'd1);

    // Test 6: 1-bit pattern saturation, clear beats increment
    idle("t6_clr", 1'b1);
    load("t6_load", 8'b1, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in("t6_one", 1'b1);
      chk("t6_seq", 32'(Match_Cnt), 32'((i + 1 < 3) ? i + 1 : 3));
    end
    step("t6_clr_vs_inc", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    chk("t6_clr_wins", 32'(Match_Cnt), 32'd0);
    chk("t6_clr_w", 32'(W), 32'd1);

    // Randomized traffic with occasional reconfiguration
    load("rnd_load", 8'b101, 3, 1'b0);
    for (int i = 0; i < 600; i++) begin
      bit         ld;
      int         l;
      logic [7:0] p;
      ld = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 4);
      p  = 8'($urandom);
      step("rnd", 1'($urandom), ($urandom_range(0, 3) != 0), ld,
           ($urandom_range(0, 24) == 0), p, l, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial sequence detector, the next generation of the fixed-pattern Seq_Det. It watches a 1-bit serial stream for a run-time programmable pattern of 1..MAX_LEN bits and selects overlapping or non-overlapping detection. It pulses a registered match flag and keeps a saturating match count. It sits between a serial bit source and the status and interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
LEN_W, $clog2(MAX_LEN+1), width of the Len port.
CNT_W, 8, width of the match counter.

Ports:
Clk  input  1  rising-edge clock.
Rst  input  1  asynchronous, active-high reset.
B  input  1  serial data bit, sampled on rising Clk when B_Vld=1.
B_Vld  input  1  qualifies B; when 0, no history shift and no match evaluation.
Cfg_Load  input  1  one-cycle strobe; latches Pattern, Len and Ovl.
Pattern  input  MAX_LEN  target pattern; bit Len-1 is received first, bit 0 last.
Len  input  LEN_W  pattern length.
Ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
Cnt_Clr  input  1  synchronous clear of Match_Cnt.
W  output  1  registered one-cycle match pulse.
Match_Cnt  output  CNT_W  saturating count of matches.
Cfg_Err  output  1  latched configuration error flag.

Behaviour:
- Rst asserted, asynchronously:
  - W=0, Match_Cnt=0, Cfg_Err=0.
  - History=0, fill=0.
  - Config registers: Pattern=0, Len=0, Ovl=1.
  - With Len=0, detection is idle until the first Cfg_Load.
- Cfg_Load=1:
  - Latch the config registers.
  - Clear history and fill.
  - Cfg_Err <= (Len==0 || Len>MAX_LEN).
  - Any B_Vld in the same cycle is ignored.
  - W=0 on the next cycle.
- While Cfg_Err=1 or Len=0: no shifts produce a match, W stays 0, Match_Cnt holds.
- History shift on B_Vld: hist <= {hist[MAX_LEN-2:0], B}; fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift values:
  - fill_next >= Len, and
  - hist_next[Len-1:0] == Pattern[Len-1:0].
  - Upper bits are masked off.
- Latency:
  - W goes high in the cycle after the rising edge that samples the completing bit.
  - W is high for exactly one cycle per match.
  - Back-to-back matches produce back-to-back W pulses.
- Overlap modes:
  - Ovl=1: history is kept after a match, so overlapping occurrences are detected.
  - Ovl=0: fill is cleared to 0 on the match edge, and the next match needs Len fresh bits.
- State is implicit in fill: EMPTY (fill=0), FILLING (0<fill<Len), ARMED (fill>=Len).
  - ARMED -> EMPTY on a match with Ovl=0.
  - Any state -> EMPTY on Cfg_Load.
- Match_Cnt:
  - Increments on each match and saturates at 2^CNT_W-1.
  - Cnt_Clr has priority over an increment in the same cycle: result is 0.
- B_Vld=0: history, fill and Match_Cnt hold; W=0.
- Reset asserted mid-pattern: all partial progress is lost.

Decomposition:
- Package seq_det_pkg holds:
  - the default MAX_LEN and CNT_W constants;
  - a typedef for the config struct {pattern, len, ovl};
  - a function computing the length mask.
- One sub-module: sat_cnt, a generic saturating counter with synchronous clear and increment enable, reused for Match_Cnt.

Test Plan:
1. Reset, then Cfg_Load Pattern=4'b1101 Len=4 Ovl=1; stream 1,1,0,1,1,0,1 with B_Vld=1 -> W pulses after the 4th and 7th bits; Match_Cnt=2.
2. Same stream with Ovl=0 -> single W pulse after the 4th bit; the 7th bit does not match (fill=3); Match_Cnt=1.
3. Pattern=2'b11 Len=2 Ovl=1; stream 1,1,1,1 -> W high 3 consecutive cycles; with Ovl=0 -> pulses after bits 2 and 4 only.
4. Stream 1,1,0 with B_Vld gaps of 3 cycles between bits, then 1 -> exactly one W pulse, one cycle after the final sampled bit; W never asserted during gaps.
5. Cfg_Load with Len=0, then Len=MAX_LEN+1 -> Cfg_Err=1 and no W on any stream; a valid Cfg_Load clears Cfg_Err; mid-pattern Rst -> all outputs 0 and partial match discarded.
6. CNT_W=2, Pattern=1'b1 Len=1; send 5 ones -> Match_Cnt 1,2,3,3,3; Cnt_Clr with a match in the same cycle -> Match_Cnt=0.
